// File: rtl/csr_hpm_counters_pkg.sv
// Shared types, CSR addresses and small helpers for the counter CSR block.
package csr_hpm_counters_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } privilege_e;

  localparam logic [11:0] MCOUNTEREN    = 12'h306;
  localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] MHPMEVENT3    = 12'h323;
  localparam logic [11:0] MCYCLE        = 12'hB00;
  localparam logic [11:0] MINSTRET      = 12'hB02;
  localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] MCYCLEH       = 12'hB80;
  localparam logic [11:0] MINSTRETH     = 12'hB82;
  localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CYCLE         = 12'hC00;
  localparam logic [11:0] INSTRET       = 12'hC02;
  localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CYCLEH        = 12'hC80;
  localparam logic [11:0] INSTRETH      = 12'hC82;
  localparam logic [11:0] HPMCOUNTER3H  = 12'hC83;

  // Counter slot 0 is mcycle, slot 1 minstret, slot k+2 is mhpmcounter(k+3).
  function automatic logic [4:0] cnt_csr_idx(input int slot);
    if (slot == 0) return 5'd0;
    if (slot == 1) return 5'd2;
    return 5'(slot + 1);
  endfunction

  function automatic logic [31:0] cnt_mask(input int num_hpm);
    return 32'h5 | (((32'h1 << num_hpm) - 32'h1) << 3);
  endfunction

endpackage

// File: rtl/csr_hpm_counters_if.sv
// CSR access bus between the execute-stage CSR mux and the counter block.
interface csr_hpm_counters_if;
  import csr_hpm_counters_pkg::*;

  privilege_e  privilege_mode;
  logic        csr_en;
  csr_op_e     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        illegal_csr;

  modport master (
    output privilege_mode, csr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit, illegal_csr
  );

  modport slave (
    input  privilege_mode, csr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_hit, illegal_csr
  );
endinterface

// File: rtl/csr_hpm_counters_counter.sv
// One free-running counter with half-word write ports; a write beats the increment.
module csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= '0;
    end else if (we_lo) begin
      value <= {value[CNT_WIDTH-1:32], wdata};
    end else if (we_hi) begin
      // Bits of wdata beyond CNT_WIDTH fall off in the cast.
      value <= CNT_WIDTH'({wdata, value[31:0]});
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine counter CSRs: mcycle, minstret, mhpmcounters, their selectors and user shadows.
module csr_hpm_counters
  import csr_hpm_counters_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  csr_hpm_counters_if.slave     csr,
  input  logic                  instr_retire,
  input  logic [NUM_EVENTS-1:0] hpm_event
);

  localparam int          NE       = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] CNT_MASK = cnt_mask(NUM_HPM);

  logic [11:0]          addr;
  logic [4:0]           idx;
  logic                 is_hi, is_inhibit, is_counteren, is_event, is_shadow, is_cnt;
  logic                 hit, legal, wr_en;
  logic [31:0]          rd_raw, new_val;
  logic [31:0]          mcountinhibit, mcounteren;
  logic [5:0]           mhpmevent [NE];
  logic [NE-1:0]        ev_fire;
  logic [CNT_WIDTH-1:0] cnt_value [NUM_HPM+2];

  assign addr         = csr.csr_addr;
  assign idx          = addr[4:0];
  assign is_hi        = addr[7];
  assign is_inhibit   = (addr == MCOUNTINHIBIT);
  assign is_counteren = (addr == MCOUNTEREN);
  assign is_event     = (addr >= MHPMEVENT3) && (addr <= MHPMEVENT3 + 12'd28);
  assign is_shadow    = (addr[11:8] == CYCLE[11:8]);
  // Index 1 (the time CSR) belongs to a different block.
  assign is_cnt       = ((addr[11:8] == MCYCLE[11:8]) || is_shadow) &&
                        (addr[6:5] == 2'b00) && (idx != 5'd1);

  assign hit   = csr.csr_en && (is_inhibit || is_counteren || is_event || is_cnt);
  assign legal = (csr.privilege_mode == PRIV_M) ?
                 !(is_shadow && csr.csr_op != CSR_OP_READ) :
                 (is_shadow && csr.csr_op == CSR_OP_READ && mcounteren[idx]);
  assign wr_en = hit && legal && (csr.csr_op != CSR_OP_READ);

  assign csr.csr_hit     = hit;
  assign csr.illegal_csr = hit && !legal;
  assign csr.csr_rdata   = (hit && legal) ? rd_raw : 32'h0;

  always_comb begin
    logic [63:0] val64;
    rd_raw = '0;
    val64  = '0;
    if (is_inhibit) begin
      rd_raw = mcountinhibit;
    end else if (is_counteren) begin
      rd_raw = mcounteren;
    end else if (is_event) begin
      for (int k = 0; k < NUM_HPM; k++)
        if (idx == 5'(k + 3)) rd_raw = {26'b0, mhpmevent[k]};
    end else if (is_cnt) begin
      for (int g = 0; g < NUM_HPM + 2; g++) begin
        if (idx == cnt_csr_idx(g)) begin
          val64  = 64'(cnt_value[g]);
          rd_raw = is_hi ? val64[63:32] : val64[31:0];
        end
      end
    end
  end

  always_comb begin
    case (csr.csr_op)
      CSR_OP_WRITE: new_val = csr.csr_wdata;
      CSR_OP_SET:   new_val = rd_raw | csr.csr_wdata;
      CSR_OP_CLEAR: new_val = rd_raw & ~csr.csr_wdata;
      default:      new_val = rd_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcountinhibit <= '0;
      mcounteren    <= '0;
      for (int k = 0; k < NE; k++) mhpmevent[k] <= '0;
    end else if (wr_en) begin
      if (is_inhibit)   mcountinhibit <= new_val & CNT_MASK;
      if (is_counteren) mcounteren    <= new_val & CNT_MASK;
      for (int k = 0; k < NUM_HPM; k++)
        if (is_event && idx == 5'(k + 3)) mhpmevent[k] <= new_val[5:0];
    end
  end

  // Selector values outside 1..NUM_EVENTS match no event and never fire.
  always_comb begin
    ev_fire = '0;
    for (int k = 0; k < NUM_HPM; k++)
      for (int e = 0; e < NUM_EVENTS; e++)
        if (mhpmevent[k] == 6'(e + 1)) ev_fire[k] = hpm_event[e];
  end

  for (genvar g = 0; g < NUM_HPM + 2; g++) begin : g_cnt
    localparam logic [4:0] CIDX = cnt_csr_idx(g);
    logic inc;

    if (g == 0) begin : g_cycle
      assign inc = !mcountinhibit[0];
    end else if (g == 1) begin : g_instret
      assign inc = instr_retire && !mcountinhibit[2];
    end else begin : g_hpm
      assign inc = !mcountinhibit[CIDX] && ev_fire[g-2];
    end

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc),
      .we_lo   (wr_en && is_cnt && !is_hi && idx == CIDX),
      .we_hi   (wr_en && is_cnt &&  is_hi && idx == CIDX),
      .wdata   (new_val),
      .value   (cnt_value[g])
    );
  end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed and randomized bench for csr_hpm_counters against a CSR-level reference model.
module tb_csr_hpm_counters;
  import csr_hpm_counters_pkg::*;

  localparam int NUM_HPM    = 4;
  localparam int CNT_WIDTH  = 64;
  localparam int NUM_EVENTS = 8;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  instr_retire = 1'b0;
  logic [NUM_EVENTS-1:0] hpm_event = '0;

  csr_hpm_counters_if csr ();

  csr_hpm_counters #(
    .NUM_HPM    (NUM_HPM),
    .CNT_WIDTH  (CNT_WIDTH),
    .NUM_EVENTS (NUM_EVENTS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .csr          (csr),
    .instr_retire (instr_retire),
    .hpm_event    (hpm_event)
  );

  always #5 clk = ~clk;

  // Reference state indexed by CSR number (0=cycle, 2=instret, 3..=hpm).
  logic [63:0] m_cnt [32];
  logic [5:0]  m_evt [32];
  logic [31:0] m_inh, m_en, reg_mask;
  logic [63:0] cw_mask;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] last_rd;
  logic        last_hit, last_ill;
  logic [11:0] addr_pool [24];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit in_map(input logic [11:0] a);
    return (a == 12'h320) || (a == 12'h306) || (a >= 12'h323 && a <= 12'h33F) ||
           (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) ||
           (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) ||
           (a >= 12'hC00 && a <= 12'hC1F && a != 12'hC01) ||
           (a >= 12'hC80 && a <= 12'hC9F && a != 12'hC81);
  endfunction

  function automatic bit impl(input int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic logic [31:0] m_value(input logic [11:0] a);
    int n = int'(a[4:0]);
    if (a == 12'h320) return m_inh;
    if (a == 12'h306) return m_en;
    if (a >= 12'h323 && a <= 12'h33F) return (n >= 3 && impl(n)) ? {26'b0, m_evt[n]} : 32'h0;
    if (!impl(n)) return 32'h0;
    return a[7] ? m_cnt[n][63:32] : m_cnt[n][31:0];
  endfunction

  task automatic do_cycle(input privilege_e pm, input bit en, input csr_op_e op,
                          input logic [11:0] a, input logic [31:0] wd,
                          input bit ret, input logic [7:0] ev);
    bit          shadow, legal, exp_hit, exp_ill;
    logic [31:0] exp_rd, old_v, new_v;
    bit          inc [32];
    int          n, sel;
    csr.privilege_mode = pm;
    csr.csr_en         = en;
    csr.csr_op         = op;
    csr.csr_addr       = a;
    csr.csr_wdata      = wd;
    instr_retire       = ret;
    hpm_event          = ev;
    #2;
    n       = int'(a[4:0]);
    shadow  = (a >= 12'hC00);
    legal   = (pm == PRIV_M) ? !(shadow && op != CSR_OP_READ)
                             : (shadow && op == CSR_OP_READ && m_en[n]);
    exp_hit = en && in_map(a);
    exp_ill = exp_hit && !legal;
    exp_rd  = (exp_hit && legal) ? m_value(a) : 32'h0;
    last_rd  = csr.csr_rdata;
    last_hit = csr.csr_hit;
    last_ill = csr.illegal_csr;
    check($sformatf("rdata@%h", a), 64'(last_rd), 64'(exp_rd));
    check($sformatf("hit@%h", a), 64'(last_hit), 64'(exp_hit));
    check($sformatf("illegal@%h", a), 64'(last_ill), 64'(exp_ill));

    for (int i = 0; i < 32; i++) begin
      sel    = int'(m_evt[i]);
      inc[i] = impl(i) && !m_inh[i] &&
               ((i == 0) || (i == 2 && ret) ||
                (i >= 3 && sel >= 1 && sel <= NUM_EVENTS && ev[sel-1]));
    end
    if (!reset_n) begin
      m_inh = '0;
      m_en  = '0;
      for (int i = 0; i < 32; i++) begin
        m_cnt[i] = '0;
        m_evt[i] = '0;
        inc[i]   = 1'b0;
      end
    end else if (exp_hit && legal && op != CSR_OP_READ) begin
      old_v = m_value(a);
      case (op)
        CSR_OP_WRITE: new_v = wd;
        CSR_OP_SET:   new_v = old_v | wd;
        default:      new_v = old_v & ~wd;
      endcase
      if (a == 12'h320) m_inh = new_v & reg_mask;
      else if (a == 12'h306) m_en = new_v & reg_mask;
      else if (a < 12'h400) begin
        if (impl(n)) m_evt[n] = new_v[5:0];
      end else if (impl(n)) begin
        if (a[7]) m_cnt[n] = {new_v, m_cnt[n][31:0]} & cw_mask;
        else      m_cnt[n] = {m_cnt[n][63:32], new_v} & cw_mask;
        inc[n] = 1'b0;
      end
    end
    for (int i = 0; i < 32; i++)
      if (inc[i]) m_cnt[i] = (m_cnt[i] + 64'd1) & cw_mask;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic [7:0] ev);
    for (int i = 0; i < cycles; i++) do_cycle(PRIV_M, 1'b0, CSR_OP_READ, 12'h000, 32'h0, 1'b0, ev);
  endtask

  task automatic mop(input csr_op_e op, input logic [11:0] a, input logic [31:0] wd);
    do_cycle(PRIV_M, 1'b1, op, a, wd, 1'b0, 8'h00);
  endtask

  initial begin
    cw_mask  = (CNT_WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_WIDTH) - 64'd1);
    reg_mask = '0;
    m_inh    = '0;
    m_en     = '0;
    for (int i = 0; i < 32; i++) begin
      if (impl(i)) reg_mask[i] = 1'b1;
      m_cnt[i] = '0;
      m_evt[i] = '0;
    end
    addr_pool = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB06,
                  12'hB86, 12'hC00, 12'hC80, 12'hC02, 12'hC03, 12'hC86, 12'h320, 12'h306,
                  12'h323, 12'h324, 12'h326, 12'h327, 12'hB01, 12'h300, 12'hB07, 12'hC81};

    reset_n = 1'b0;
    idle(2, 8'h00);
    reset_n = 1'b1;
    idle(10, 8'h00);
    mop(CSR_OP_READ, MCYCLE, 32'h0);
    check("mcycle_after_10_idle", 64'(last_rd), 64'd10);
    mop(CSR_OP_READ, MINSTRET, 32'h0);
    check("minstret_after_reset", 64'(last_rd), 64'd0);
    mop(CSR_OP_READ, MHPMCOUNTER3, 32'h0);
    check("hpm3_after_reset", 64'(last_rd), 64'd0);

    mop(CSR_OP_WRITE, MCYCLEH, 32'hFFFF_FFFF);
    mop(CSR_OP_WRITE, MCYCLE, 32'hFFFF_FFFE);
    mop(CSR_OP_READ, MCYCLE, 32'h0);
    check("mcycle_lo_written", 64'(last_rd), 64'hFFFF_FFFE);
    mop(CSR_OP_READ, MCYCLEH, 32'h0);
    check("mcycle_hi_all_ones", 64'(last_rd), 64'hFFFF_FFFF);
    mop(CSR_OP_READ, MCYCLE, 32'h0);
    check("mcycle_lo_wrapped", 64'(last_rd), 64'h0);
    mop(CSR_OP_READ, MCYCLEH, 32'h0);
    check("mcycle_hi_wrapped", 64'(last_rd), 64'h0);

    mop(CSR_OP_WRITE, MHPMEVENT3, 32'd2);
    idle(5, 8'h02);
    mop(CSR_OP_READ, MHPMCOUNTER3, 32'h0);
    check("hpm3_five_events", 64'(last_rd), 64'd5);
    mop(CSR_OP_SET, MCOUNTINHIBIT, 32'h8);
    idle(3, 8'h02);
    mop(CSR_OP_READ, MHPMCOUNTER3, 32'h0);
    check("hpm3_inhibited", 64'(last_rd), 64'd5);

    do_cycle(PRIV_M, 1'b1, CSR_OP_WRITE, MINSTRET, 32'd100, 1'b1, 8'h00);
    mop(CSR_OP_READ, MINSTRET, 32'h0);
    check("minstret_write_wins", 64'(last_rd), 64'd100);

    do_cycle(PRIV_U, 1'b1, CSR_OP_READ, CYCLE, 32'h0, 1'b0, 8'h00);
    check("u_cycle_denied_ill", 64'(last_ill), 64'd1);
    check("u_cycle_denied_rd", 64'(last_rd), 64'd0);
    mop(CSR_OP_SET, MCOUNTEREN, 32'h1);
    do_cycle(PRIV_U, 1'b1, CSR_OP_READ, CYCLE, 32'h0, 1'b0, 8'h00);
    check("u_cycle_allowed_ill", 64'(last_ill), 64'd0);

    mop(CSR_OP_WRITE, INSTRET, 32'd5);
    check("m_shadow_write_ill", 64'(last_ill), 64'd1);
    mop(CSR_OP_READ, MINSTRET, 32'h0);
    check("minstret_unchanged", 64'(last_rd), 64'd100);
    mop(CSR_OP_READ, 12'h300, 32'h0);
    check("outside_hit", 64'(last_hit), 64'd0);
    check("outside_ill", 64'(last_ill), 64'd0);
    mop(CSR_OP_READ, 12'hB01, 32'h0);
    check("b01_hit", 64'(last_hit), 64'd0);

    mop(CSR_OP_WRITE, 12'hB10, 32'd123);
    mop(CSR_OP_READ, 12'hB10, 32'h0);
    check("unimpl_counter_rd", 64'(last_rd), 64'd0);
    mop(CSR_OP_WRITE, 12'h330, 32'd3);
    mop(CSR_OP_READ, 12'h330, 32'h0);
    check("unimpl_event_rd", 64'(last_rd), 64'd0);
    mop(CSR_OP_WRITE, MCOUNTINHIBIT, 32'hFFFF_FFFF);
    mop(CSR_OP_READ, MCOUNTINHIBIT, 32'h0);
    check("inhibit_mask", 64'(last_rd), 64'h7D);
    mop(CSR_OP_CLEAR, MCOUNTINHIBIT, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      do_cycle(($urandom_range(0, 3) == 0) ? PRIV_U : PRIV_M,
               ($urandom_range(0, 3) != 0),
               csr_op_e'($urandom_range(0, 3)),
               addr_pool[$urandom_range(0, 23)],
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
               1'($urandom_range(0, 1)),
               8'($urandom));
    end

    reset_n = 1'b0;
    mop(CSR_OP_WRITE, MCYCLE, 32'h55);
    reset_n = 1'b1;
    mop(CSR_OP_READ, MCYCLE, 32'h0);
    check("mcycle_after_mid_reset", 64'(last_rd), 64'd0);
    mop(CSR_OP_READ, MCOUNTEREN, 32'h0);
    check("counteren_after_mid_reset", 64'(last_rd), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
